// File: rtl/router_pkg.sv
// Shared constants for the router FIFO slice: geometry, counter width and the
// header length field position.
package router_pkg;

    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CNT_W      = 7;

    // Payload length field inside a header byte
    localparam int unsigned LEN_MSB = 7;
    localparam int unsigned LEN_LSB = 2;

    // Bytes still to be delivered after a header: payload length plus the parity byte
    function automatic logic [CNT_W-1:0] pkt_len(input logic [LEN_MSB:LEN_LSB] len);
        return CNT_W'(len) + 1'b1;
    endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// Storage array for router_fifo: one synchronous write port, one asynchronous
// read port. Contents are never reset; the pointer flags keep stale entries unread.
module router_fifo_mem #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned WIDTH  = 9,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the accepted entry at the write index
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/router_fifo.sv
// Router output FIFO: stores bytes with a header flag, tracks the remaining
// length of the packet being read and zeroes data_out at end of packet.
module router_fifo #(
    parameter int unsigned DEPTH  = router_pkg::FIFO_DEPTH,
    parameter int unsigned DATA_W = router_pkg::DATA_W
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              soft_reset,
    input  logic              write_enb,
    input  logic              read_enb,
    input  logic              lfd_state,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty
);

    import router_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] dout_d;
    logic              lfd_q;
    logic              wr_acc;
    logic              rd_acc;
    logic [DATA_W:0]   rd_entry;

    // Flags decode straight from the registered pointers
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A flush suppresses both ports for that edge
    assign wr_acc = write_enb & ~full & ~soft_reset;
    assign rd_acc = read_enb & ~empty & ~soft_reset;

    router_fifo_mem #(
        .DEPTH  (DEPTH),
        .WIDTH  (DATA_W + 1),
        .ADDR_W (AW)
    ) u_mem (
        .clock (clock),
        .we    (wr_acc),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata ({lfd_q, data_in}),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (rd_entry)
    );

    // Next-state for pointers, packet counter and output register
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        dout_d   = data_out;
        if (soft_reset) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            dout_d   = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                dout_d   = rd_entry[DATA_W-1:0];
                if (rd_entry[DATA_W]) begin
                    cnt_d = pkt_len(rd_entry[LEN_MSB:LEN_LSB]);
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end else if (cnt_q == '0) begin
                // Packet fully delivered: idle the output bus
                dout_d = '0;
            end
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            lfd_q    <= 1'b0;
            data_out <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            lfd_q    <= lfd_state;
            data_out <= dout_d;
        end
    end

endmodule
